// File: rtl/srt4_pkg.sv
// Shared types and constants for the SRT-4 divider control slice.
package srt4_pkg;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_ITER  = DW_DEF/2 + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    LOAD = 3'd2,
    ITER = 3'd3,
    POST = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/srt4_iter_counter.sv
// Iteration down-counter with a matching 0-based up-index and last-step detect.
module srt4_iter_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] idx,
  output logic             last,
  output logic             zero
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idx;

  // clear beats load beats step; a zero count never steps, so idx cannot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (load) begin
      r_cnt <= cnt_in;
      r_idx <= '0;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
      r_idx <= r_idx + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign idx  = r_idx;
  assign last = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});
  assign zero = (r_cnt == '0);
endmodule

// File: rtl/srt4_div_ctrl.sv
// Sequencing FSM for the integer SRT-4 divider: accept, normalise, iterate,
// correct, present result; divide-by-zero skips straight to the result.
module srt4_div_ctrl
  import srt4_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = DW/2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    dividend_in,
  input  logic [DW-1:0]    divisor_in,
  input  logic             flush,
  output logic             pre_start,
  output logic [DW-1:0]    pre_dividend,
  output logic [DW-1:0]    pre_divisor,
  input  logic [CNT_W-1:0] pre_iterations,
  input  logic [CNT_W-1:0] pre_recovery,
  output logic             iter_load,
  output logic             iter_en,
  output logic [CNT_W-1:0] iter_idx,
  output logic             post_en,
  output logic [CNT_W-1:0] recovery_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             div_by_zero
);
  state_t           r_state, w_next;
  logic [DW-1:0]    r_dividend, r_divisor;
  logic [CNT_W-1:0] r_recovery;
  logic             r_dbz;
  logic [CNT_W-1:0] w_cnt;
  logic             w_last, w_zero, w_accept;

  assign w_accept = (r_state == IDLE) && in_valid && !flush;

  srt4_iter_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (r_state == PRE),
    .dec    (r_state == ITER),
    .cnt_in (pre_iterations),
    .cnt    (w_cnt),
    .idx    (iter_idx),
    .last   (w_last),
    .zero   (w_zero)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state; flush overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = PRE;
      PRE:  w_next = (r_divisor == '0) ? DONE : LOAD;
      LOAD: w_next = ITER;
      ITER: if (w_last || w_zero) w_next = POST;
      POST: w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // operand capture on accept; kept across flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
    end else if (w_accept) begin
      r_dividend <= dividend_in;
      r_divisor  <= divisor_in;
    end
  end

  // normaliser results and zero-divisor flag, latched at the end of PRE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recovery <= '0;
      r_dbz      <= 1'b0;
    end else if (flush) begin
      r_dbz      <= 1'b0;
    end else if (r_state == PRE) begin
      r_recovery <= pre_recovery;
      r_dbz      <= (r_divisor == '0);
    end
  end

  // strobes are state decodes; a zero count in ITER suppresses the step
  assign in_ready     = (r_state == IDLE);
  assign pre_start    = (r_state == PRE);
  assign iter_load    = (r_state == LOAD);
  assign iter_en      = (r_state == ITER) && !w_zero;
  assign post_en      = (r_state == POST);
  assign out_valid    = (r_state == DONE);
  assign pre_dividend = r_dividend;
  assign pre_divisor  = r_divisor;
  assign recovery_q   = r_recovery;
  assign div_by_zero  = r_dbz;
endmodule

// File: tb/tb_srt4_div_ctrl.sv
// Self-checking bench: directed table, hand sequences for flush/reset, and
// random operations against a cycle-timeline model of the controller.
module tb_srt4_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, pre_start, iter_load, iter_en, post_en;
  logic        out_valid, out_ready, div_by_zero;
  logic [31:0] dividend_in, divisor_in, pre_dividend, pre_divisor;
  logic [15:0] pre_iterations, pre_recovery, iter_idx, recovery_q;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  srt4_div_ctrl #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend_in(dividend_in), .divisor_in(divisor_in), .flush(flush),
    .pre_start(pre_start), .pre_dividend(pre_dividend), .pre_divisor(pre_divisor),
    .pre_iterations(pre_iterations), .pre_recovery(pre_recovery),
    .iter_load(iter_load), .iter_en(iter_en), .iter_idx(iter_idx),
    .post_en(post_en), .recovery_q(recovery_q), .out_valid(out_valid),
    .out_ready(out_ready), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    int          iters;
    int          rec;
    int          dly;   // cycles out_ready is held low after out_valid rises
    int          fl;    // cycle at which flush is asserted, 0 = never
    int          lat;   // expected first out_valid cycle, 0 = never
  } vec_t;

  typedef struct {
    bit ir, ps, ld, it, po, ov;
    int idx;
    bit cidx;
    bit dz;
    bit cdz;
  } exp_t;

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  // Expected outputs in cycle k after the accept edge (accept edge = cycle 0).
  function automatic exp_t model(input int k, input int n, input bit dz, input int d, input int fl);
    exp_t e;
    int v, last_ov;
    e = '{default: 0};
    if (fl > 0 && k > fl) begin
      e.ir = 1; e.cidx = 1; e.idx = 0; e.cdz = 1; e.dz = 0;
      return e;
    end
    v       = dz ? 2 : 4 + n;
    last_ov = v + d;
    e.ps = (k == 1);
    if (!dz) begin
      e.ld = (k == 2);
      e.it = (k >= 3) && (k <= 2 + n);
      e.po = (k == 3 + n);
    end
    e.ov = (k >= v) && (k <= last_ov);
    e.ir = (k == last_ov + 1);
    if (k >= 2) begin
      e.cidx = 1;
      e.idx  = dz ? 0 : (k <= 2) ? 0 : (k <= 2 + n) ? k - 3 : n;
      e.cdz  = 1;
      e.dz   = dz;
    end
    return e;
  endfunction

  task automatic run_op(input vec_t v, output int first_ov);
    exp_t e;
    bit   dz;
    int   vlat, last_ov, last;
    dz       = (v.dvs == 0);
    vlat     = dz ? 2 : 4 + v.iters;
    last_ov  = vlat + v.dly;
    last     = (v.fl > 0) ? v.fl + 1 : last_ov + 1;
    first_ov = 0;
    chk("idle_ready", 0, in_ready, 1);
    dividend_in    = v.dvd;
    divisor_in     = v.dvs;
    in_valid       = 1;
    pre_iterations = 16'($urandom);
    @(posedge clk); #1;
    for (int k = 1; k <= last; k++) begin
      e = model(k, v.iters, dz, v.dly, v.fl);
      chk("in_ready",  k, in_ready,  e.ir);
      chk("pre_start", k, pre_start, e.ps);
      chk("iter_load", k, iter_load, e.ld);
      chk("iter_en",   k, iter_en,   e.it);
      chk("post_en",   k, post_en,   e.po);
      chk("out_valid", k, out_valid, e.ov);
      chk("pre_dividend", k, pre_dividend, v.dvd);
      chk("pre_divisor",  k, pre_divisor,  v.dvs);
      if (e.cidx) chk("iter_idx", k, iter_idx, 64'(e.idx));
      if (e.cdz)  chk("div_by_zero", k, div_by_zero, e.dz);
      if (k >= 2 && v.fl == 0) chk("recovery_q", k, recovery_q, 64'(v.rec));
      if (out_valid && first_ov == 0) first_ov = k;
      // drive this cycle's inputs; junk operands/in_valid must be ignored
      pre_iterations = (k == 1) ? 16'(v.iters) : 16'($urandom);
      pre_recovery   = (k == 1) ? 16'(v.rec)   : 16'($urandom);
      dividend_in    = $urandom;
      divisor_in     = $urandom;
      in_valid       = (k < last) ? 1'($urandom) : 1'b0;
      flush          = (k == v.fl);
      out_ready      = (k == last_ov) ? 1'b1 : (k < vlat) ? 1'($urandom) : 1'b0;
      if (k < last) begin @(posedge clk); #1; end
    end
    in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   fo, n;

  initial begin
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    dividend_in = 0; divisor_in = 0; pre_iterations = 0; pre_recovery = 0;
    #12;
    chk("rst_in_ready",  0, in_ready, 1);
    chk("rst_pre_start", 0, pre_start, 0);
    chk("rst_iter_load", 0, iter_load, 0);
    chk("rst_iter_en",   0, iter_en, 0);
    chk("rst_post_en",   0, post_en, 0);
    chk("rst_out_valid", 0, out_valid, 0);
    chk("rst_iter_idx",  0, iter_idx, 0);
    chk("rst_recovery",  0, recovery_q, 0);
    chk("rst_dbz",       0, div_by_zero, 0);
    chk("rst_pre_dvd",   0, pre_dividend, 0);
    chk("rst_pre_dvs",   0, pre_divisor, 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    tbl[0] = '{32'h1234_5678, 32'h8000_0000,  1, 32, 0, 0,  5};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 17,  1, 0, 0, 21};
    tbl[2] = '{32'h0BAD_CAFE, 32'h0000_0000,  5,  3, 0, 0,  2};
    tbl[3] = '{32'h00AB_CDEF, 32'h0000_0100, 12,  9, 5, 0, 16};
    tbl[4] = '{32'h7777_0000, 32'h0000_0003, 13,  4, 0, 5,  0};
    tbl[5] = '{32'h1357_9BDF, 32'h8000_0000,  1, 32, 0, 0,  5};
    tbl[6] = '{32'h0000_0001, 32'h0000_0000,  9,  2, 2, 0,  2};
    foreach (tbl[i]) begin
      run_op(tbl[i], fo);
      chk($sformatf("latency_tbl%0d", i), fo, 64'(fo), 64'(tbl[i].lat));
    end

    // flush together with in_valid in IDLE: nothing is accepted
    in_valid = 1; flush = 1; dividend_in = 32'hDEAD_BEEF; divisor_in = 32'h5;
    @(posedge clk); #1;
    chk("flush_idle_ready", 0, in_ready, 1);
    chk("flush_idle_pre",   0, pre_start, 0);
    chk("flush_idle_dvd",   0, pre_dividend, 32'h0000_0001);
    in_valid = 0; flush = 0;
    @(posedge clk); #1;

    // asynchronous reset mid-ITER of a 13-step op
    in_valid = 1; dividend_in = 32'h4444_4444; divisor_in = 32'h10;
    pre_iterations = 13; pre_recovery = 7;
    @(posedge clk); #1; in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_iter_en", 5, iter_en, 1);
    #2 rst = 1;
    #1;
    chk("arst_in_ready",  0, in_ready, 1);
    chk("arst_iter_en",   0, iter_en, 0);
    chk("arst_out_valid", 0, out_valid, 0);
    chk("arst_iter_idx",  0, iter_idx, 0);
    chk("arst_recovery",  0, recovery_q, 0);
    chk("arst_pre_dvd",   0, pre_dividend, 0);
    @(posedge clk); #1; rst = 0;
    rv = '{32'h2468_ACE0, 32'h8000_0000, 1, 32, 1, 0, 5};
    run_op(rv, fo);
    chk("latency_after_rst", fo, 64'(fo), 5);

    // random operations
    for (int r = 0; r < 60; r++) begin
      n        = $urandom_range(1, 17);
      rv.dvd   = $urandom;
      rv.dvs   = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      rv.iters = n;
      rv.rec   = $urandom_range(0, 32);
      rv.dly   = $urandom_range(0, 3);
      rv.lat   = (rv.dvs == 0) ? 2 : 4 + n;
      rv.fl    = 0;
      if (rv.dvs != 0 && $urandom_range(0, 4) == 0) begin
        rv.fl  = $urandom_range(2, rv.lat - 1);
        rv.lat = 0;
      end
      run_op(rv, fo);
      chk("latency_rand", fo, 64'(fo), 64'(rv.lat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/srt4_div_ctrl.md
Name: srt4_div_ctrl

Overview:
- Sequencing controller for the integer SRT-4 divider.
- Accepts an operand pair over a valid/ready handshake and holds the operands stable for the combinational normaliser (pre_processing).
- Captures its iteration count and recovery shift, then steps the radix-4 iteration datapath exactly that many cycles.
- Triggers post-correction, presents the result over a valid/ready handshake, and short-circuits divide-by-zero.

Parameters:
- DW, 32, operand width in bits.
- CNT_W, DW/2, width of the iteration count and recovery shift fields, matching the normaliser outputs.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept operands.
- dividend_in  in  DW  dividend.
- divisor_in  in  DW  divisor.
- flush  in  1  synchronous abort, returns to IDLE.
- pre_start  out  1  drives the normaliser start input.
- pre_dividend  out  DW  registered dividend to the normaliser.
- pre_divisor  out  DW  registered divisor to the normaliser.
- pre_iterations  in  CNT_W  iteration count from the normaliser.
- pre_recovery  in  CNT_W  recovery shift from the normaliser.
- iter_load  out  1  load the normalised operands into the iteration registers.
- iter_en  out  1  perform one radix-4 step this cycle.
- iter_idx  out  CNT_W  0-based index of the current step.
- post_en  out  1  run the sign correction / denormalise stage this cycle.
- recovery_q  out  CNT_W  latched recovery shift for the post stage.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- div_by_zero  out  1  qualifies out_valid: divisor was 0.

Behaviour:
- Reset value of every register and output is 0: state=IDLE, operand registers, iter_cnt, iter_idx, recovery_q, div_by_zero.
- in_ready, pre_start, iter_load, iter_en, post_en and out_valid are pure decodes of the state. Their reset values follow from state=IDLE: in_ready=1, all others 0.
- Reset asserted in any state aborts the operation immediately; nothing pending survives.
- FSM states: IDLE, PRE, LOAD, ITER, POST, DONE. The state register holds the enum from srt4_pkg.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register dividend_in/divisor_in into pre_dividend/pre_divisor and go to PRE.
- PRE:
  - pre_start=1 for exactly one cycle.
  - At the end of the cycle, capture pre_iterations into iter_cnt, pre_recovery into recovery_q, and set iter_idx=0.
  - If pre_divisor==0: set div_by_zero=1 and go to DONE, skipping LOAD/ITER/POST.
  - Otherwise clear div_by_zero and go to LOAD.
- LOAD: iter_load=1 for one cycle, then go to ITER.
- ITER:
  - iter_en=1 every cycle.
  - Each cycle iter_cnt decrements by 1 and iter_idx increments by 1.
  - When iter_cnt==1, go to POST after this cycle. ITER therefore lasts exactly N=pre_iterations cycles, with N in 1..DW/2+1.
  - If iter_cnt==0 is ever seen in ITER (defensive), go to POST with no further iter_en.
- POST: post_en=1 for one cycle, then go to DONE.
- DONE:
  - out_valid=1, and recovery_q and div_by_zero are held.
  - On out_ready, return to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency, counting the accept edge as cycle 0:
  - PRE at cycle 1, LOAD at cycle 2, ITER at cycles 3..2+N, POST at cycle 3+N, out_valid first high at cycle 4+N.
  - Divide-by-zero: out_valid first high at cycle 2.
- flush:
  - Any state goes to IDLE on the next edge; all strobes are deasserted and out_valid is dropped without handshake.
  - div_by_zero and iter_idx are cleared; the operand registers are kept.
  - flush with in_valid in IDLE: flush wins and nothing is accepted.
- Width rules:
  - iter_cnt and iter_idx are CNT_W unsigned.
  - iter_idx never wraps, since N ≤ DW/2+1 < 2^CNT_W.
- in_valid outside IDLE is ignored (in_ready=0). Operands must not change the registered copies after acceptance.

Decomposition:
- Package srt4_pkg holds:
  - state enum {IDLE, PRE, LOAD, ITER, POST, DONE};
  - localparams DW_DEF=32 and CNT_W_DEF=16;
  - constant MAX_ITER=DW/2+1.
- One sub-module is natural: srt4_iter_counter.
  - Its interface is load/dec, cnt_in, cnt, idx, last.
  - It owns the down-counter, up-index and last detection.
  - The FSM remains in srt4_div_ctrl.

Test Plan:
- divisor=0x8000_0000, dividend=0x1234_5678, iterations=1, recovery=32 → pre_start at cycle 1, iter_load at cycle 2, iter_en at cycle 3 only, post_en at cycle 4, out_valid at cycle 5, recovery_q=32.
- divisor=1, dividend=0xFFFF_FFFF, iterations=17, recovery=1 → iter_en high for cycles 3..19 with iter_idx 0..16, post_en at cycle 20, out_valid at cycle 21.
- divisor=0 → div_by_zero=1, out_valid at cycle 2, iter_load/iter_en/post_en never asserted.
- divisor=0x0000_0100, out_ready held low 5 cycles after out_valid → out_valid, recovery_q=9 and div_by_zero stable; in_ready stays 0 until the cycle after out_ready=1.
- flush asserted at the 3rd ITER cycle of a 13-iteration op → IDLE next cycle, no post_en, out_valid never set; the following op with divisor=0x8000_0000 completes in 5 cycles.
- rst pulsed mid-ITER, asynchronously between clock edges → all outputs 0 and in_ready=1 immediately; the next op runs normally.
